// File: rtl/pe_pkg.sv
// Shared definitions for the PE loader and pe_control.
//   ldr_state_t : loader FSM states
//   PW/QW/SW    : widths of the P (filters), Q (channels), S (row length) fields
//   CNTW        : width of word counts and scratchpad offsets
package pe_pkg;

  localparam int unsigned PW   = 5;
  localparam int unsigned QW   = 3;
  localparam int unsigned SW   = 4;
  localparam int unsigned CNTW = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_IF,
    ST_LOAD_F,
    ST_FLUSH,
    ST_GAP,
    ST_RUN,
    ST_FIN
  } ldr_state_t;

endpackage

// File: rtl/ldr_offset_cnt.sv
// Clearable offset counter with a terminal-value compare.
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear (wins over en)
//   en        : increment
//   term      : terminal value to compare against
//   cnt       : current offset
//   at_term   : cnt == term
module ldr_offset_cnt
  import pe_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic [CNTW-1:0] term,
  output logic [CNTW-1:0] cnt,
  output logic            at_term
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNTW'(1);
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/pe_loader.sv
// Streams one job's ifmap then filter words from the GLB into the PE
// scratchpads, then runs the load/start handshake with pe_control.
//   clk, rstn          : clock, async active-low reset
//   go, P, Q, S        : job request and dimensions (sampled in IDLE)
//   glb_rd/addr/rdata  : GLB read port (data 1 cycle after read)
//   pe_wr_if/pe_wr_f   : scratchpad write strobes (ifmap / filter)
//   pe_waddr/pe_wdata  : scratchpad write offset / data
//   load, start        : to pe_control
//   pe_complete        : from pe_control
//   busy, done, cfg_err: status; done/cfg_err are 1-cycle pulses
module pe_loader
  import pe_pkg::*;
#(
  parameter int unsigned     AW      = 16,
  parameter int unsigned     DW      = 16,
  parameter logic [AW-1:0]   IF_BASE = AW'(16'h0000),
  parameter logic [AW-1:0]   F_BASE  = AW'(16'h1000)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            go,
  input  logic [PW-1:0]   P,
  input  logic [QW-1:0]   Q,
  input  logic [SW-1:0]   S,
  output logic            glb_rd,
  output logic [AW-1:0]   glb_addr,
  input  logic [DW-1:0]   glb_rdata,
  output logic            pe_wr_if,
  output logic            pe_wr_f,
  output logic [CNTW-1:0] pe_waddr,
  output logic [DW-1:0]   pe_wdata,
  output logic            load,
  output logic            start,
  input  logic            pe_complete,
  output logic            busy,
  output logic            done,
  output logic            cfg_err
);

  ldr_state_t      state, state_nx;
  logic [PW-1:0]   p_q;
  logic [QW-1:0]   q_q;
  logic [SW-1:0]   s_q;
  logic            err_q;
  logic            zero_dim;
  logic [CNTW-1:0] n_if, n_f, term, off;
  logic            at_term, cnt_clr, cnt_en;
  logic            tag_vld, tag_if;
  logic [CNTW-1:0] tag_off;

  assign zero_dim = (P == '0) || (Q == '0) || (S == '0);
  assign n_if     = CNTW'(s_q) * CNTW'(q_q);
  assign n_f      = n_if * CNTW'(p_q);
  assign term     = (state == ST_LOAD_F) ? n_f - CNTW'(1) : n_if - CNTW'(1);

  ldr_offset_cnt u_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .term    (term),
    .cnt     (off),
    .at_term (at_term)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      p_q   <= '0;
      q_q   <= '0;
      s_q   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && go) begin
        err_q <= zero_dim;
        if (!zero_dim) begin
          p_q <= P;
          q_q <= Q;
          s_q <= S;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    glb_rd   = 1'b0;
    glb_addr = '0;
    load     = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    cfg_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (go) state_nx = zero_dim ? ST_FIN : ST_LOAD_IF;
      end
      ST_LOAD_IF: begin
        glb_rd   = 1'b1;
        glb_addr = IF_BASE + AW'(off);
        load     = 1'b1;
        // Clearing on the last ifmap word lets LOAD_F begin at offset 0
        // in the very next cycle, so there is no read bubble.
        if (at_term) begin
          cnt_clr  = 1'b1;
          state_nx = ST_LOAD_F;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_LOAD_F: begin
        glb_rd   = 1'b1;
        glb_addr = F_BASE + AW'(off);
        load     = 1'b1;
        if (at_term) begin
          cnt_clr  = 1'b1;
          state_nx = ST_FLUSH;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_FLUSH: begin
        load     = 1'b1;
        state_nx = ST_GAP;
      end
      ST_GAP: state_nx = ST_RUN;
      ST_RUN: begin
        start = 1'b1;
        if (pe_complete) state_nx = ST_FIN;
      end
      ST_FIN: begin
        done     = 1'b1;
        cfg_err  = err_q;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Write tag trails each read by one cycle, matching GLB read latency.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= 1'b0;
      tag_if  <= 1'b0;
      tag_off <= '0;
    end else begin
      tag_vld <= glb_rd;
      tag_if  <= (state == ST_LOAD_IF);
      tag_off <= off;
    end
  end

  assign pe_wr_if = tag_vld & tag_if;
  assign pe_wr_f  = tag_vld & ~tag_if;
  assign pe_waddr = tag_vld ? tag_off : '0;
  assign pe_wdata = tag_vld ? glb_rdata : '0;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pe_loader.sv
// Directed table-driven bench for pe_loader: per-job cycle-by-cycle
// expectations from the job timing, plus reset sequences.
module tb_pe_loader;
  import pe_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam logic [15:0] IFB = 16'h0000;
  localparam logic [15:0] FB  = 16'h1000;

  logic            clk, rstn, go, pe_complete;
  logic [PW-1:0]   P;
  logic [QW-1:0]   Q;
  logic [SW-1:0]   S;
  logic            glb_rd, pe_wr_if, pe_wr_f, load, start, busy, done, cfg_err;
  logic [AW-1:0]   glb_addr;
  logic [DW-1:0]   glb_rdata, pe_wdata;
  logic [CNTW-1:0] pe_waddr;

  pe_loader #(.AW(AW), .DW(DW), .IF_BASE(IFB), .F_BASE(FB)) dut (
    .clk(clk), .rstn(rstn), .go(go), .P(P), .Q(Q), .S(S),
    .glb_rd(glb_rd), .glb_addr(glb_addr), .glb_rdata(glb_rdata),
    .pe_wr_if(pe_wr_if), .pe_wr_f(pe_wr_f), .pe_waddr(pe_waddr),
    .pe_wdata(pe_wdata), .load(load), .start(start),
    .pe_complete(pe_complete), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gdata(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // GLB model: data for the address read one cycle earlier.
  always @(posedge clk) glb_rdata <= glb_rd ? gdata(glb_addr) : 16'hDEAD;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({glb_rd, glb_addr, pe_wr_if, pe_wr_f, pe_waddr, pe_wdata,
                load, start, busy, done, cfg_err});
  endfunction

  typedef struct {
    int p, q, s;
    int nif, n, rise, kc, done_k;
    bit err, spur, gopulse;
  } vec_t;

  function automatic vec_t mk(input int p, q, s, nif, n, rise, kc, done_k,
                              input bit err, spur, gopulse);
    vec_t v;
    v.p = p; v.q = q; v.s = s; v.nif = nif; v.n = n; v.rise = rise;
    v.kc = kc; v.done_k = done_k; v.err = err; v.spur = spur; v.gopulse = gopulse;
    return v;
  endfunction

  task automatic run_job(input int idx, input vec_t v);
    int rd_bad = 0, addr_bad = 0, wr_bad = 0, wa_bad = 0, wd_bad = 0;
    int load_bad = 0, st_bad = 0, busy_bad = 0, err_bad = 0;
    int done_cnt = 0, rise_k = 0, load_cnt = 0;
    logic prev_start = 1'b0;
    logic [15:0] exp_addr, prev_addr = '0;
    bit e_rd, e_wif, e_wf, e_load, e_start, e_busy, e_done, e_err;
    string pre = $sformatf("job%0d", idx);

    @(negedge clk);
    go = 1'b1; P = PW'(v.p); Q = QW'(v.q); S = SW'(v.s);
    for (int k = 1; k <= v.done_k; k++) begin
      @(negedge clk);
      if (k == 1) begin
        go = 1'b0; P = 5'd7; Q = 3'd7; S = 4'd7;
      end
      e_rd     = (k <= v.n);
      exp_addr = (k <= v.nif) ? IFB + 16'(k - 1) : FB + 16'(k - v.nif - 1);
      e_wif    = (k >= 2) && (k <= v.nif + 1);
      e_wf     = (k >= v.nif + 2) && (k <= v.n + 1);
      e_load   = (v.n > 0) && (k <= v.n + 1);
      e_start  = (v.rise > 0) && (k >= v.rise) && (k <= v.kc);
      e_busy   = 1'b1;
      e_done   = (k == v.done_k);
      e_err    = v.err && (k == v.done_k);

      if (glb_rd !== e_rd) rd_bad++;
      if (e_rd && glb_addr !== exp_addr) addr_bad++;
      if (pe_wr_if !== e_wif || pe_wr_f !== e_wf) wr_bad++;
      if (e_wif && pe_waddr !== 12'(k - 2)) wa_bad++;
      if (e_wf && pe_waddr !== 12'(k - v.nif - 2)) wa_bad++;
      if ((e_wif || e_wf) && pe_wdata !== gdata(prev_addr)) wd_bad++;
      if (load !== e_load) load_bad++;
      if (start !== e_start) st_bad++;
      if (busy !== e_busy) busy_bad++;
      if (cfg_err !== e_err) err_bad++;
      if (done === 1'b1) done_cnt++;
      if (start === 1'b1 && !prev_start && rise_k == 0) rise_k = k;
      if (load === 1'b1) load_cnt++;
      prev_start = start;
      prev_addr  = exp_addr;

      pe_complete = (k == v.kc) || (v.spur && k == 2);
      go = v.gopulse && ((k == v.nif + 2) || (k == v.rise + 2));
    end
    pe_complete = 1'b0;
    go = 1'b0;

    check({pre, "_rd"},      64'(rd_bad),   64'd0);
    check({pre, "_addr"},    64'(addr_bad), 64'd0);
    check({pre, "_wr"},      64'(wr_bad),   64'd0);
    check({pre, "_waddr"},   64'(wa_bad),   64'd0);
    check({pre, "_wdata"},   64'(wd_bad),   64'd0);
    check({pre, "_load"},    64'(load_bad), 64'd0);
    check({pre, "_start"},   64'(st_bad),   64'd0);
    check({pre, "_busy"},    64'(busy_bad), 64'd0);
    check({pre, "_cfg_err"}, 64'(err_bad),  64'd0);
    check({pre, "_ndone"},   64'(done_cnt), 64'd1);
    check({pre, "_rise"},    64'(rise_k),   64'(v.rise));
    check({pre, "_loadlen"}, 64'(load_cnt), (v.n > 0) ? 64'(v.n + 1) : 64'd0);
  endtask

  vec_t tbl[8];

  initial begin
    //          p   q  s   nif  n     rise  kc    done  err spur gop
    tbl[0] = mk(1,  1, 1,  1,   2,    5,    8,    9,    0,  0,   0);
    tbl[1] = mk(2,  1, 3,  3,   9,    12,   20,   21,   0,  0,   0);
    tbl[2] = mk(3,  2, 0,  0,   0,    0,    0,    1,    1,  0,   0);
    tbl[3] = mk(0,  5, 2,  0,   0,    0,    0,    1,    1,  0,   0);
    tbl[4] = mk(2,  1, 3,  3,   9,    12,   20,   21,   0,  1,   1);
    tbl[5] = mk(3,  7, 5,  35,  140,  143,  150,  151,  0,  0,   0);
    tbl[6] = mk(31, 7, 15, 105, 3360, 3363, 3365, 3366, 0,  0,   0);
    tbl[7] = mk(31, 7, 15, 105, 3360, 3363, 3364, 3365, 0,  0,   0);

    rstn = 1'b0; go = 1'b0; pe_complete = 1'b0; P = '0; Q = '0; S = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", all_out(), 64'd0);
    rstn = 1'b1;

    // Abandon a P=2,Q=1,S=3 job with reset during cycle 4.
    @(negedge clk);
    go = 1'b1; P = 5'd2; Q = 3'd1; S = 4'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      go = 1'b0;
    end
    check("midjob_load", 64'(load), 64'd1);
    check("midjob_addr", 64'(glb_addr), 64'(FB));
    #2 rstn = 1'b0;
    #1 check("async_reset_outputs", all_out(), 64'd0);
    @(negedge clk);
    check("held_reset_outputs", all_out(), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_job(i, tbl[i]);

    @(negedge clk);
    check("idle_after_jobs", 64'({busy, start, load, done}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pe_loader.md
# pe_loader

Upstream sequencer for `pe_control` and its processing element. On a `go` request it streams one job's ifmap words and then its filter words from the global buffer (GLB) into the PE scratchpads, holding `load` high throughout. It then drops `load`, raises `start`, and holds it until the PE reports `complete`. It owns the `load`/`start` handshake that `pe_control` consumes, and it snapshots the job dimensions P, Q and S for the duration of the job.

## Interface
- `AW`, default 16: GLB address width.
- `DW`, default 16: data word width.
- `IF_BASE`, default 16'h0000: GLB base address of the ifmap words.
- `F_BASE`, default 16'h1000: GLB base address of the filter words.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `go` in 1: job request, sampled only in IDLE.
- `P` in 5: filter count.
- `Q` in 3: channel count.
- `S` in 4: filter row length.
- `glb_rd` out 1: GLB read strobe.
- `glb_addr` out AW: GLB read address.
- `glb_rdata` in DW: GLB read data, valid exactly 1 cycle after `glb_rd`.
- `pe_wr_if` out 1: ifmap scratchpad write strobe.
- `pe_wr_f` out 1: filter scratchpad write strobe.
- `pe_waddr` out 12: scratchpad write offset.
- `pe_wdata` out DW: scratchpad write data.
- `load` out 1: drives `pe_control.load`.
- `start` out 1: drives `pe_control.start`.
- `pe_complete` in 1: from `pe_control.complete`.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: 1-cycle pulse at the end of a job.
- `cfg_err` out 1: 1-cycle pulse, coincident with `done`, when the job has a zero dimension.

## Operation
- Word counts are computed from the snapshot: N_IF = S·Q (max 105) and N_F = S·Q·P (max 3255). Both are computed at 12-bit width with no truncation.
- States:
  - IDLE
  - LOAD_IF
  - LOAD_F
  - FLUSH
  - GAP
  - RUN
  - FIN
- IDLE:
  - `go` with P, Q and S all nonzero → snapshot P/Q/S, clear the offset counter, go to LOAD_IF.
  - `go` with any of P, Q or S zero → FIN with `cfg_err` set; no GLB or PE activity occurs.
- LOAD_IF:
  - Each cycle: `glb_rd`=1, `glb_addr`=IF_BASE+off, then off++.
  - When off = N_IF−1 → off clears and the state goes to LOAD_F with no bubble.
- LOAD_F:
  - Each cycle: `glb_rd`=1, `glb_addr`=F_BASE+off.
  - When off = N_F−1 → FLUSH.
- Write pipeline:
  - A 1-stage registered tag (valid, is_if, offset) follows each read.
  - The cycle after a read: `pe_wdata`=`glb_rdata`, `pe_waddr`=tagged offset, and `pe_wr_if` or `pe_wr_f` is set according to the tag.
  - `pe_wr_if` and `pe_wr_f` are never high together.
- FLUSH: the last filter write occurs in this cycle; `load` is still 1. Next state is GAP.
- GAP: `load`=0 and `start`=0 for one cycle, which guarantees `load` is low before `start` rises. Next state is RUN.
- RUN: `start`=1 and is held.
  - `pe_complete`=1 → FIN.
  - `pe_complete` is ignored in every other state.
- FIN: `start`=0, `done`=1 for one cycle → IDLE. Because `start` is low at least one cycle, the next job produces a fresh `start` rising edge.
- `load`=1 from the first LOAD_IF cycle through FLUSH inclusive, and 0 in all other states.
- `go` while `busy` is ignored and is not queued.
- Addresses wrap modulo 2^AW.

## Timing
- Reset values: every output is 0 and the state is IDLE. This applies immediately on `rstn` low, including mid-load or mid-run.
- Reset mid-job abandons the job. Any scratchpad writes already made are not undone; the PE sees `load`=0 and `start`=0.
- With `go` sampled at cycle 0:
  - reads occur in cycles 1..N_IF+N_F;
  - writes occur in cycles 2..N_IF+N_F+1;
  - `load` is high for exactly N_IF+N_F+1 cycles;
  - GAP is cycle N_IF+N_F+2;
  - `start` rises at cycle N_IF+N_F+3.
- `done` is asserted the cycle after `pe_complete` is sampled in RUN.
- Zero-dimension job: `done` and `cfg_err` are asserted at cycle 1.
- Throughput is one word per cycle with no backpressure; the GLB must accept a read every cycle.

## Structure
- Shared package `pe_pkg` holds:
  - the state enum `ldr_state_t`;
  - the width constants `PW`=5, `QW`=3, `SW`=4 and `CNTW`=12;
  - the widths of P, Q and S, which `pe_control` also uses.
- Sub-module `ldr_offset_cnt`: a 12-bit clearable counter with a terminal-compare output, instantiated once and reused for both load phases.

## Test plan
- P=1, Q=1, S=1, `go` at cycle 0:
  - reads at IF_BASE (cycle 1) and F_BASE (cycle 2);
  - `pe_wr_if` at cycle 2 and `pe_wr_f` at cycle 3, each with offset 0;
  - `load` high in cycles 1–3;
  - `start` rises at cycle 5.
- P=2, Q=1, S=3:
  - 3 ifmap and 6 filter reads;
  - `load` high for 10 cycles;
  - `pe_waddr` sequence 0,1,2 then 0..5;
  - `pe_complete` at cycle 20 → `done` at cycle 21 and `start`=0 at cycle 21.
- S=0 (any P, Q) → `done`=`cfg_err`=1 at cycle 1; `glb_rd`, `load` and `start` never assert.
- `go` pulsed during LOAD_F and during RUN → ignored; exactly one `done` is produced; a spurious `pe_complete` during LOAD_IF has no effect.
- `rstn` low at cycle 4 of a P=2, Q=1, S=3 job → all outputs 0 asynchronously; a new job after release starts again at IF_BASE.
- P=31, Q=7, S=15:
  - N_F = 3255 with no counter overflow;
  - last filter read at F_BASE+3254;
  - back-to-back jobs show a `start` low gap of at least one cycle.
